// File: rtl/fp_pkg.sv
// Shared single-precision field constants, flag/entry types and the classifier
// used by the FP ALU result paths.
package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic nan;
        logic inf;
        logic zero;
    } fp_flags_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // One FIFO entry: canonical word plus the subtractor flags as received.
    typedef struct packed {
        logic [31:0] s;
        logic        ovf;
        logic        unf;
    } fp_entry_t;

    function automatic fp_class_t fp_classify(input logic [31:0] word);
        fp_class_t             c;
        logic [7:0]            e;
        logic [MANT_W-1:0]     m;
        e      = word[EXP_MSB:EXP_LSB];
        m      = word[MANT_W-1:0];
        c.zero = (word[SIGN_BIT-1:0] == '0);
        c.inf  = (e == EXP_MAX) && (m == '0);
        c.nan  = (e == EXP_MAX) && (m != '0);
        return c;
    endfunction

endpackage

// File: rtl/fp_canon.sv
// Combinational result canonicalizer: overflow forces signed infinity,
// underflow forces signed zero, overflow wins when both are flagged.
module fp_canon
    import fp_pkg::*;
(
    input  logic [31:0] s,
    input  logic        overflow,
    input  logic        underflow,
    output logic [31:0] canon_s
);

    always_comb begin
        canon_s = s;
        if (overflow) begin
            canon_s = {s[SIGN_BIT], EXP_MAX, {MANT_W{1'b0}}};
        end else if (underflow) begin
            canon_s = {s[SIGN_BIT], 31'h0};
        end
    end

endmodule

// File: rtl/fp_sub_result_buffer.sv
// Subtractor result buffer: canonicalizes results, queues them in a small FIFO,
// and tracks sticky overflow/underflow status plus a saturating result count.
module fp_sub_result_buffer
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_s,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_s,
    output logic [4:0]       out_flags,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] result_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    FULL_XOR = {1'b1, {AW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready and out_valid come only from registered pointers, so neither
    // side's ready/valid ever depends combinationally on the other side.
    fp_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [31:0]     canon_s;
    fp_entry_t       head;
    fp_class_t       head_cls;
    fp_flags_t       head_flags;

    fp_canon u_canon (
        .s         (in_s),
        .overflow  (in_overflow),
        .underflow (in_underflow),
        .canon_s   (canon_s)
    );

    assign full      = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= '{s: canon_s, ovf: in_overflow, unf: in_underflow};
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign head_cls = fp_classify(head.s);

    always_comb begin
        head_flags      = '0;
        head_flags.ovf  = head.ovf;
        head_flags.unf  = head.unf;
        head_flags.nan  = head_cls.nan;
        head_flags.inf  = head_cls.inf;
        head_flags.zero = head_cls.zero;
    end

    // The cleared head word classifies as zero, so flags are masked while empty.
    assign out_s     = head.s;
    assign out_flags = out_valid ? head_flags : 5'b0;

    // A set in the same cycle as stat_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            sticky_ovf <= (sticky_ovf && !stat_clr) || (push && in_overflow);
            sticky_unf <= (sticky_unf && !stat_clr) || (push && in_underflow);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_count <= '0;
        end else if (push) begin
            if (stat_clr) begin
                result_count <= CNT_W'(1);
            end else if (result_count != CNT_MAX) begin
                result_count <= result_count + CNT_W'(1);
            end
        end else if (stat_clr) begin
            result_count <= '0;
        end
    end

endmodule

// File: tb/tb_fp_sub_result_buffer.sv
// Self-checking bench for fp_sub_result_buffer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fp_sub_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_s;
    logic             in_overflow;
    logic             in_underflow;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_s;
    logic [4:0]       out_flags;
    logic             sticky_ovf;
    logic             sticky_unf;
    logic             stat_clr;
    logic [CNT_W-1:0] result_count;

    fp_sub_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_s         (in_s),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_s        (out_s),
        .out_flags    (out_flags),
        .sticky_ovf   (sticky_ovf),
        .sticky_unf   (sticky_unf),
        .stat_clr     (stat_clr),
        .result_count (result_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: {canonical s, ovf, unf} per accepted result
    logic [33:0] exp_q[$];
    int          m_cnt;
    logic        m_sovf;
    logic        m_sunf;
    int          n_checks;
    int          n_fails;

    typedef struct {
        logic [31:0] s;
        logic        ovf;
        logic        unf;
        logic [31:0] exp_s;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_canon(input logic [31:0] s, input logic ovf, input logic unf);
        if (ovf) return (s & 32'h8000_0000) | 32'h7F80_0000;
        if (unf) return s & 32'h8000_0000;
        return s;
    endfunction

    function automatic logic [4:0] ref_flags(input logic [33:0] e);
        logic [31:0] mag;
        mag = e[33:2] & 32'h7FFF_FFFF;
        return {e[1], e[0], mag > 32'h7F80_0000, mag == 32'h7F80_0000, mag == 32'h0};
    endfunction

    task automatic check_all();
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < DEPTH});
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
        check("sticky_ovf", {31'b0, sticky_ovf}, {31'b0, m_sovf});
        check("sticky_unf", {31'b0, sticky_unf}, {31'b0, m_sunf});
        check("result_count", 32'(result_count), 32'(m_cnt));
        if (exp_q.size() > 0) begin
            check("out_s", out_s, exp_q[0][33:2]);
            check("out_flags", {27'b0, out_flags}, {27'b0, ref_flags(exp_q[0])});
        end
    endtask

    // Driver: apply one cycle of inputs, advance the model, then check.
    task automatic cycle(input logic v, input logic [31:0] s, input logic ovf,
                         input logic unf, input logic ordy, input logic clr);
        logic m_push;
        logic m_pop;
        in_valid     = v;
        in_s         = s;
        in_overflow  = ovf;
        in_underflow = unf;
        out_ready    = ordy;
        stat_clr     = clr;
        m_push = v && (exp_q.size() < DEPTH);
        m_pop  = ordy && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back({ref_canon(s, ovf, unf), ovf, unf});
        if (m_push) m_cnt = clr ? 1 : (m_cnt == CMAX ? CMAX : m_cnt + 1);
        else if (clr) m_cnt = 0;
        m_sovf = (m_sovf && !clr) || (m_push && ovf);
        m_sunf = (m_sunf && !clr) || (m_push && unf);
        check_all();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_cnt    = 0;
        m_sovf   = 1'b0;
        m_sunf   = 1'b0;
        vecs[0] = '{32'h4040_0000, 1'b0, 1'b0, 32'h4040_0000, 5'b00000};
        vecs[1] = '{32'h7F81_2345, 1'b1, 1'b0, 32'h7F80_0000, 5'b10010};
        vecs[2] = '{32'h8001_2345, 1'b0, 1'b1, 32'h8000_0000, 5'b01001};
        vecs[3] = '{32'h7FC0_0000, 1'b0, 1'b0, 32'h7FC0_0000, 5'b00100};
        vecs[4] = '{32'hFF80_0000, 1'b0, 1'b0, 32'hFF80_0000, 5'b00010};
        vecs[5] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 5'b00001};
        vecs[6] = '{32'h3F80_0000, 1'b1, 1'b1, 32'h7F80_0000, 5'b11010};
        vecs[7] = '{32'hC000_0000, 1'b0, 1'b1, 32'h8000_0000, 5'b01001};

        rst = 1'b1;
        in_valid = 1'b0; in_s = '0; in_overflow = 1'b0; in_underflow = 1'b0;
        out_ready = 1'b0; stat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst out_s", out_s, 32'h0);
        check("rst out_flags", {27'b0, out_flags}, 32'h0);
        check("rst sticky", {30'b0, sticky_ovf, sticky_unf}, 32'h0);
        check("rst result_count", 32'(result_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector table: one push, check head against the table, then pop it.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vecs[i].s, vecs[i].ovf, vecs[i].unf, 1'b0, 1'b0);
            check("vec out_valid", {31'b0, out_valid}, 32'd1);
            check("vec out_s", out_s, vecs[i].exp_s);
            check("vec out_flags", {27'b0, out_flags}, {27'b0, vecs[i].exp_flags});
            check("vec result_count", 32'(result_count), 32'(i + 1));
            idle(1'b1);
        end

        // Fill to full with the consumer stalled; fifth push is refused.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h4100_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("full in_ready", {31'b0, in_ready}, 32'd0);
        check("full head", out_s, 32'h4100_0000);
        idle(1'b1);
        check("after pop in_ready", {31'b0, in_ready}, 32'd1);
        repeat (4) idle(1'b1);
        check("drained out_valid", {31'b0, out_valid}, 32'd0);

        // Streaming with the consumer always ready.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'h4200_0000 + 32'(i * 3), 1'b0, 1'b0, 1'b1, 1'b0);
            check("stream in_ready", {31'b0, in_ready}, 32'd1);
        end
        check("stream result_count", 32'(result_count), 32'd20);
        idle(1'b1);

        // stat_clr racing a push: set and count-to-one win.
        cycle(1'b1, 32'h4000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        check("clr+push sticky_ovf", {31'b0, sticky_ovf}, 32'd1);
        check("clr+push result_count", 32'(result_count), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr sticky_ovf", {31'b0, sticky_ovf}, 32'd0);
        check("clr result_count", 32'(result_count), 32'd0);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h4300_0000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        rst = 1'b1;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst in_ready", {31'b0, in_ready}, 32'd1);
        check("async rst sticky_unf", {31'b0, sticky_unf}, 32'd0);
        exp_q.delete();
        m_cnt  = 0;
        m_sovf = 1'b0;
        m_sunf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h4480_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post rst head", out_s, 32'h4480_0000);
        idle(1'b1);
        check("post rst alone", {31'b0, out_valid}, 32'd0);

        // Randomized traffic, long enough to saturate the counter.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            logic        ro;
            logic        ru;
            rs = $urandom;
            case ($urandom_range(0, 5))
                0: rs = {rs[31], 8'hFF, rs[22:0]};
                1: rs = {rs[31], 31'h0};
                default: ;
            endcase
            ro = ($urandom_range(0, 5) == 0);
            ru = ($urandom_range(0, 5) == 0);
            cycle($urandom_range(0, 3) != 0, rs, ro, ru,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
        end
        repeat (DEPTH + 1) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
